scfifo_showahead_ctrl: RTL and testbench
========================================

Name: scfifo_showahead_ctrl

Overview:
- Single-clock show-ahead FIFO controller that drives the write and read ports of an external simple-dual-port M20K wrapper.
- The wrapper's read port has a 2-stage pipeline: an address register, then an output register. Both stages are clock-enabled by mem_re.
- This block converts that stalled, latency-2 read path into a zero-latency show-ahead interface: q is valid whenever empty=0, and rdreq acknowledges the current word.
- Sits between producer/consumer logic and the RAM primitive in the scfifo family.

Parameters:
- WIDTH, 8, data width.
- ADDR_WIDTH, 8, RAM address width; DEPTH = 1<<ADDR_WIDTH words.
- ALMOST_FULL_LEVEL, DEPTH-4, almost_full asserts when usedw >= this value.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous active-high reset.
- wrreq  in  1  push request.
- data  in  WIDTH  push data.
- rdreq  in  1  pop/acknowledge of the current q.
- q  out  WIDTH  head-of-FIFO data, valid when empty=0.
- empty  out  1  no word presented on q.
- full  out  1  usedw == DEPTH.
- almost_full  out  1  usedw >= ALMOST_FULL_LEVEL.
- usedw  out  ADDR_WIDTH+1  words accepted and not yet popped; includes prefetched words.
- overflow  out  1  one-cycle pulse when wrreq is rejected.
- underflow  out  1  one-cycle pulse when rdreq is ignored.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  ADDR_WIDTH  RAM write address.
- mem_din  out  WIDTH  RAM write data.
- mem_re  out  1  RAM read clock enable; advances both read stages.
- mem_raddr  out  ADDR_WIDTH  RAM read address, sampled when mem_re=1.
- mem_dout  in  WIDTH  RAM output register.

Behaviour:
- Reset (async, arst=1): the following registers and flags are cleared.
  - wptr=0, rptr=0, v1=0, v2=0, vq=0, q=0, usedw=0.
  - empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - RAM contents are don't-care after reset.
- RAM model assumed (read side, on a clk edge with mem_re=1):
  - The address register loads mem_raddr.
  - The output register loads mem[address register].
- Mixed-port read-during-write is don't-care. The controller never samples an address into stage 1 on the same edge that address is written.
- Write path:
  - wr_ok = wrreq & !full.
  - mem_we = wr_ok, mem_waddr = wptr, mem_din = data (combinational).
  - wptr increments and wraps modulo DEPTH on wr_ok.
- Read pipeline state:
  - v1: stage-1 address valid.
  - v2: mem_dout valid.
  - vq: q register valid.
- Read pipeline control:
  - avail = (rptr != wptr) | (usedw_ram_full). Track with a separate RAM occupancy count ram_cnt rather than pointer compare, so that a full RAM is distinguished from an empty one.
  - pop = rdreq & vq.
  - q_load = v2 & (!vq | pop).
  - mem_re = !v2 | q_load.
  - mem_raddr = rptr.
- On each edge with mem_re=1:
  - v2 <= v1.
  - v1 <= avail.
  - rptr increments if avail.
- q update, on each edge:
  - If q_load: q <= mem_dout and vq <= 1.
  - Else if pop: vq <= 0.
- empty = !vq.
- Sustains one pop per cycle once the pipeline is primed.
- Latency:
  - First write into an empty FIFO at edge N: empty falls after edge N+3, and q = that data.
  - Pop at edge M with a primed pipeline: the next word is on q after edge M (no bubble).
- usedw arithmetic:
  - usedw <= usedw + wr_ok - pop.
  - Width ADDR_WIDTH+1.
  - Never exceeds DEPTH and never underflows.
- Flags: full and almost_full are registered, derived from the next usedw.
- Full boundary:
  - wrreq with full=1 is ignored and pulses overflow.
  - wrreq & rdreq together while full: the write is still rejected, because full is sampled pre-pop. The pop proceeds and usedw becomes DEPTH-1.
- Empty boundary:
  - rdreq with empty=1 is ignored, pulses underflow, and leaves state unchanged.
  - wrreq & rdreq on an empty FIFO: the write is accepted; nothing is popped.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap or duplicate.
- Reset mid-operation: all in-flight prefetch is discarded. The FIFO is empty on the first edge after arst deasserts.

Test Plan:
- Reset, then write 0x11 at cycle 0 with no reads -> empty=1 through cycle 2; empty=0 and q=0x11 after edge 3; usedw=1 from cycle 1.
- Write 0x01..0x08 back-to-back, then assert rdreq continuously once empty=0 -> q sequence 0x01..0x08, one per cycle with no bubble; empty=1 after the 8th pop; usedw=0.
- ADDR_WIDTH=4: write 16 words -> full=1 and usedw=16; a 17th wrreq pulses overflow and usedw stays 16; then simultaneous wrreq+rdreq -> write rejected, usedw=15.
- Stream 40 words through a DEPTH=16 FIFO with random rdreq/wrreq duty (about 50%) -> output order matches input, covering pointer wrap; usedw equals the scoreboard count every cycle.
- Read stall: fill 4 words, hold rdreq=0 for 10 cycles -> q stable at the first word, mem_re=0 once v1, v2 and vq are set; resume reads -> remaining 3 words follow in order.
- Assert arst for 1 cycle mid-stream with 5 words held -> empty=1, usedw=0, full=0 immediately; the next write of 0xAA appears on q 3 edges later.

Source files
------------

// File: rtl/scfifo_showahead_ctrl.sv
// Show-ahead FIFO controller wrapping a simple-dual-port RAM whose read path has a
// two-stage (address register + output register) pipeline enabled by mem_re_o.
module scfifo_showahead_ctrl #(
    parameter int unsigned WIDTH             = 8,
    parameter int unsigned ADDR_WIDTH        = 8,
    parameter int unsigned ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  wrreq_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  rdreq_i,
    output logic [WIDTH-1:0]      q_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   usedw_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [WIDTH-1:0]      mem_din_o,
    output logic                  mem_re_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [WIDTH-1:0]      mem_dout_i
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH:0] AfLevel = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDR_WIDTH:0]   usedw_q, usedw_d;
    logic                  v1_q, v1_d;
    logic                  v2_q, v2_d;
    logic                  vq_q, vq_d;
    logic [WIDTH-1:0]      q_q, q_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_ok, pop, q_load, mem_re, avail, fetch;

    always_comb begin
        wr_ok  = wrreq_i & ~full_q;
        pop    = rdreq_i & vq_q;
        q_load = v2_q & (~vq_q | pop);
        mem_re = ~v2_q | q_load;
        // Words written but not yet fetched; registered so that an address is never
        // sampled into stage 1 on the edge it is written.
        avail  = (ram_cnt_q != '0);
        fetch  = mem_re & avail;

        wptr_d    = wptr_q + ADDR_WIDTH'(wr_ok);
        rptr_d    = rptr_q + ADDR_WIDTH'(fetch);
        ram_cnt_d = ram_cnt_q + (ADDR_WIDTH + 1)'(wr_ok) - (ADDR_WIDTH + 1)'(fetch);
        usedw_d   = usedw_q + (ADDR_WIDTH + 1)'(wr_ok) - (ADDR_WIDTH + 1)'(pop);

        v1_d = v1_q;
        v2_d = v2_q;
        if (mem_re) begin
            v2_d = v1_q;
            v1_d = avail;
        end

        q_d  = q_q;
        vq_d = vq_q;
        if (q_load) begin
            q_d  = mem_dout_i;
            vq_d = 1'b1;
        end else if (pop) begin
            vq_d = 1'b0;
        end

        full_d      = (usedw_d == DepthW);
        afull_d     = (usedw_d >= AfLevel);
        overflow_d  = wrreq_i & full_q;
        underflow_d = rdreq_i & ~vq_q;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_cnt_q   <= '0;
            usedw_q     <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            vq_q        <= 1'b0;
            q_q         <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_cnt_q   <= ram_cnt_d;
            usedw_q     <= usedw_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            vq_q        <= vq_d;
            q_q         <= q_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign q_o           = q_q;
    assign empty_o       = ~vq_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign usedw_o       = usedw_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;
    assign mem_we_o      = wr_ok;
    assign mem_waddr_o   = wptr_q;
    assign mem_din_o     = data_i;
    assign mem_re_o      = mem_re;
    assign mem_raddr_o   = rptr_q;

endmodule

// File: tb/tb_scfifo_showahead_ctrl.sv
// Bench for scfifo_showahead_ctrl with a 16-deep RAM model and a queue scoreboard.
module tb_scfifo_showahead_ctrl;

    localparam int W  = 8;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int AF = 12;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          wrreq = 1'b0;
    logic [W-1:0]  data = '0;
    logic          rdreq = 1'b0;
    logic [W-1:0]  q;
    logic          empty, full, almost_full, overflow, underflow;
    logic [AW:0]   usedw;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [W-1:0]  mem_din;
    logic [W-1:0]  mem_dout;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    scfifo_showahead_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .ALMOST_FULL_LEVEL(AF)) dut (
        .clk_i(clk), .arst_i(arst), .wrreq_i(wrreq), .data_i(data), .rdreq_i(rdreq),
        .q_o(q), .empty_o(empty), .full_o(full), .almost_full_o(almost_full),
        .usedw_o(usedw), .overflow_o(overflow), .underflow_o(underflow),
        .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_din_o(mem_din),
        .mem_re_o(mem_re), .mem_raddr_o(mem_raddr), .mem_dout_i(mem_dout)
    );

    // RAM with registered address and registered output, both enabled by mem_re
    logic [W-1:0]  ram [D];
    logic [AW-1:0] ram_areg = '0;
    logic [W-1:0]  ram_oreg = '0;
    assign mem_dout = ram_oreg;
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_din;
        if (mem_re) begin
            ram_areg <= mem_raddr;
            ram_oreg <= ram[ram_areg];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wrreq = 1'b0; rdreq = 1'b0; arst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 6;
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_afull got=%0b exp=0", almost_full); end
        if (usedw !== '0) begin failures++; $display("FAIL reset_usedw got=%0d exp=0", usedw); end
        if (q !== '0) begin failures++; $display("FAIL reset_q got=%0h exp=0", q); end
        if ({overflow, underflow} !== 2'b00) begin
            failures++; $display("FAIL reset_ovf_udf got=%b exp=00", {overflow, underflow});
        end
        arst = 1'b0;
        sb.delete();
        tick();
    endtask

    task automatic test_first_write();
        wrreq = 1'b1; data = 8'h11;
        tick();
        wrreq = 1'b0;
        for (int e = 0; e < 3; e++) begin
            checks += 2;
            if (empty !== 1'b1) begin failures++; $display("FAIL first_empty_e%0d got=%0b exp=1", e, empty); end
            if (usedw !== 5'd1) begin failures++; $display("FAIL first_usedw_e%0d got=%0d exp=1", e, usedw); end
            tick();
        end
        checks += 2;
        if (empty !== 1'b0) begin failures++; $display("FAIL first_empty_e3 got=%0b exp=0", empty); end
        if (q !== 8'h11) begin failures++; $display("FAIL first_q got=%0h exp=11", q); end
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        checks += 2;
        if (empty !== 1'b1) begin failures++; $display("FAIL first_pop_empty got=%0b exp=1", empty); end
        if (usedw !== 5'd0) begin failures++; $display("FAIL first_pop_usedw got=%0d exp=0", usedw); end
    endtask

    task automatic test_back_to_back();
        int wait_cnt;
        for (int i = 1; i <= 8; i++) begin
            wrreq = 1'b1; data = W'(i);
            tick();
        end
        wrreq = 1'b0;
        wait_cnt = 0;
        while (empty && wait_cnt < 10) begin tick(); wait_cnt++; end
        checks++;
        if (empty !== 1'b0) begin failures++; $display("FAIL b2b_prime got=empty exp=data"); end
        rdreq = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks += 2;
            if (empty !== 1'b0) begin failures++; $display("FAIL b2b_bubble_%0d got=1 exp=0", i); end
            if (q !== W'(i)) begin failures++; $display("FAIL b2b_q_%0d got=%0h exp=%0h", i, q, i); end
            tick();
        end
        rdreq = 1'b0;
        checks += 2;
        if (empty !== 1'b1) begin failures++; $display("FAIL b2b_end_empty got=%0b exp=1", empty); end
        if (usedw !== 5'd0) begin failures++; $display("FAIL b2b_end_usedw got=%0d exp=0", usedw); end
    endtask

    task automatic test_full();
        logic [W-1:0] d;
        int guard;
        for (int i = 0; i < D; i++) begin
            d = W'($urandom);
            wrreq = 1'b1; data = d; sb.push_back(d);
            tick();
            checks++;
            if (almost_full !== (i + 1 >= AF)) begin
                failures++; $display("FAIL full_afull_%0d got=%0b exp=%0b", i + 1, almost_full, i + 1 >= AF);
            end
        end
        checks += 2;
        if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", full); end
        if (usedw !== 5'd16) begin failures++; $display("FAIL full_usedw got=%0d exp=16", usedw); end
        data = 8'hEE;
        tick();
        wrreq = 1'b0;
        checks += 2;
        if (overflow !== 1'b1) begin failures++; $display("FAIL full_ovf got=%0b exp=1", overflow); end
        if (usedw !== 5'd16) begin failures++; $display("FAIL full_ovf_usedw got=%0d exp=16", usedw); end
        tick();
        checks += 2;
        if (overflow !== 1'b0) begin failures++; $display("FAIL full_ovf_pulse got=%0b exp=0", overflow); end
        if (q !== sb[0]) begin failures++; $display("FAIL full_head got=%0h exp=%0h", q, sb[0]); end
        wrreq = 1'b1; rdreq = 1'b1; data = 8'hDD;
        tick();
        wrreq = 1'b0; rdreq = 1'b0;
        void'(sb.pop_front());
        checks += 3;
        if (usedw !== 5'd15) begin failures++; $display("FAIL full_rw_usedw got=%0d exp=15", usedw); end
        if (full !== 1'b0) begin failures++; $display("FAIL full_rw_full got=%0b exp=0", full); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL full_rw_ovf got=%0b exp=1", overflow); end
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            if (!empty) begin
                checks++;
                if (q !== sb[0]) begin failures++; $display("FAIL full_drain got=%0h exp=%0h", q, sb[0]); end
                rdreq = 1'b1; void'(sb.pop_front());
            end else rdreq = 1'b0;
            tick();
            guard++;
        end
        rdreq = 1'b0;
        checks++;
        if (sb.size() != 0 || usedw !== 5'd0) begin
            failures++; $display("FAIL full_drain_end got=%0d left exp=0 usedw=%0d", sb.size(), usedw);
        end
    endtask

    task automatic test_random_stream();
        int sent, rcvd, cyc, starve;
        logic wr, rd, acc, popm, was_empty;
        logic [W-1:0] d;
        sent = 0; rcvd = 0; cyc = 0; starve = 0;
        while ((sent < 40 || rcvd < 40) && cyc < 2000) begin
            if (!empty) begin
                checks++;
                if (sb.size() == 0 || q !== sb[0]) begin
                    failures++; $display("FAIL rand_q cyc=%0d got=%0h exp=%0h", cyc, q,
                                         sb.size() ? sb[0] : 8'h00);
                end
                starve = 0;
            end else if (sb.size() > 0) begin
                starve++;
            end
            checks++;
            if (starve > 4) begin failures++; $display("FAIL rand_starve cyc=%0d got=%0d exp<=4", cyc, starve); end
            wr = ($urandom % 2 == 0) && sent < 40;
            rd = ($urandom % 2 == 0);
            d = W'($urandom);
            wrreq = wr; rdreq = rd; data = d;
            was_empty = empty;
            acc = wr && sb.size() < D;
            popm = rd && !empty;
            tick();
            if (popm && sb.size() > 0) begin void'(sb.pop_front()); rcvd++; end
            if (acc) begin sb.push_back(d); sent++; end
            checks += 5;
            if (usedw !== (AW + 1)'(sb.size())) begin
                failures++; $display("FAIL rand_usedw cyc=%0d got=%0d exp=%0d", cyc, usedw, sb.size());
            end
            if (full !== (sb.size() == D)) begin failures++; $display("FAIL rand_full cyc=%0d got=%0b", cyc, full); end
            if (almost_full !== (sb.size() >= AF)) begin
                failures++; $display("FAIL rand_afull cyc=%0d got=%0b", cyc, almost_full);
            end
            if (overflow !== (wr && !acc)) begin failures++; $display("FAIL rand_ovf cyc=%0d got=%0b", cyc, overflow); end
            if (underflow !== (rd && was_empty)) begin
                failures++; $display("FAIL rand_udf cyc=%0d got=%0b exp=%0b", cyc, underflow, rd && was_empty);
            end
            cyc++;
        end
        wrreq = 1'b0; rdreq = 1'b0;
        checks++;
        if (sent != 40 || rcvd != 40) begin
            failures++; $display("FAIL rand_done got=%0d/%0d exp=40/40", sent, rcvd);
        end
    endtask

    task automatic test_read_stall();
        logic [W-1:0] w[4];
        for (int i = 0; i < 4; i++) begin
            w[i] = W'($urandom);
            wrreq = 1'b1; data = w[i];
            tick();
        end
        wrreq = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks += 2;
            if (q !== w[0] || empty !== 1'b0) begin
                failures++; $display("FAIL stall_q c=%0d got=%0h exp=%0h", c, q, w[0]);
            end
            if (c >= 2 && mem_re !== 1'b0) begin
                failures++; $display("FAIL stall_mem_re c=%0d got=%0b exp=0", c, mem_re);
            end
            tick();
        end
        rdreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q !== w[i] || empty !== 1'b0) begin
                failures++; $display("FAIL stall_resume_%0d got=%0h exp=%0h", i, q, w[i]);
            end
            tick();
        end
        rdreq = 1'b0;
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL stall_end_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1; data = W'($urandom);
            tick();
        end
        wrreq = 1'b0;
        tick();
        arst = 1'b1;
        #1;
        checks += 3;
        if (empty !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%0b exp=1", empty); end
        if (usedw !== 5'd0) begin failures++; $display("FAIL rmid_usedw got=%0d exp=0", usedw); end
        if (full !== 1'b0) begin failures++; $display("FAIL rmid_full got=%0b exp=0", full); end
        @(posedge clk);
        #1;
        arst = 1'b0;
        wrreq = 1'b1; data = 8'hAA;
        tick();
        wrreq = 1'b0;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (empty !== 1'b1) begin failures++; $display("FAIL rmid_lat_e%0d got=%0b exp=1", e, empty); end
            tick();
        end
        checks += 2;
        if (empty !== 1'b0) begin failures++; $display("FAIL rmid_after got=%0b exp=0", empty); end
        if (q !== 8'hAA) begin failures++; $display("FAIL rmid_q got=%0h exp=aa", q); end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_back_to_back();
        test_full();
        test_reset();
        test_random_stream();
        test_reset();
        test_read_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
